// File: rtl/matrix_job_scheduler.sv
// Job scheduler: buffers matrix job descriptors in a FIFO and launches them one at a
// time on a matrix processor, retiring each on procDone (zero-count jobs retire directly).
module matrix_job_scheduler #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jobValid,
    output logic             jobReady,
    input  logic [WIDTH-1:0] jobMatrixAddr,
    input  logic [WIDTH-1:0] jobDataInAddr,
    input  logic [WIDTH-1:0] jobDataOutAddr,
    input  logic [13:0]      jobCount,
    input  logic             flush,
    output logic             procStart,
    output logic [WIDTH-1:0] procMatrixAddr,
    output logic [WIDTH-1:0] procDataInAddr,
    output logic [WIDTH-1:0] procDataOutAddr,
    output logic [13:0]      procWorkItemCount,
    input  logic             procDone,
    output logic             busy,
    output logic [$clog2(DEPTH):0] queueLevel,
    output logic [15:0]      jobsCompleted
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] m_addr;
        logic [WIDTH-1:0] i_addr;
        logic [WIDTH-1:0] o_addr;
        logic [13:0]      cnt;
    } job_t;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    state_t        state, state_nxt;
    job_t          mem [DEPTH];
    job_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   level;
    logic          full, empty, push, pop, launch, retire;

    assign full     = (level == (PW+1)'(DEPTH));
    assign empty    = (level == '0);
    // Ready is independent of jobValid; reset and flush both close the door.
    assign jobReady = !rst && !full && !flush;
    assign push     = jobValid && jobReady;
    assign head     = mem[rd_ptr];

    assign procStart  = (state == LAUNCH);
    assign busy       = (state != IDLE);
    assign queueLevel = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        launch    = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                // flush pre-empts any pop in the same cycle
                if (!empty && !flush) begin
                    pop = 1'b1;
                    if (head.cnt != '0) begin
                        launch    = 1'b1;
                        state_nxt = LAUNCH;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            LAUNCH: state_nxt = RUN;
            RUN: begin
                if (procDone) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{jobMatrixAddr, jobDataInAddr, jobDataOutAddr, jobCount};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            procMatrixAddr    <= '0;
            procDataInAddr    <= '0;
            procDataOutAddr   <= '0;
            procWorkItemCount <= '0;
        end else if (launch) begin
            procMatrixAddr    <= head.m_addr;
            procDataInAddr    <= head.i_addr;
            procDataOutAddr   <= head.o_addr;
            procWorkItemCount <= head.cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         jobsCompleted <= '0;
        else if (retire) jobsCompleted <= jobsCompleted + 1'b1;
    end
endmodule

// File: tb/tb_matrix_job_scheduler.sv
// Directed bench for matrix_job_scheduler: single job, fill/order, zero-count, flush,
// spurious done, reset mid-run and completion-counter wrap.
module tb_matrix_job_scheduler;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             jobValid = 1'b0;
    logic             jobReady;
    logic [WIDTH-1:0] jobMatrixAddr = '0, jobDataInAddr = '0, jobDataOutAddr = '0;
    logic [13:0]      jobCount = '0;
    logic             flush = 1'b0;
    logic             procStart;
    logic [WIDTH-1:0] procMatrixAddr, procDataInAddr, procDataOutAddr;
    logic [13:0]      procWorkItemCount;
    logic             procDone = 1'b0;
    logic             busy;
    logic [$clog2(DEPTH):0] queueLevel;
    logic [15:0]      jobsCompleted;

    int n_tests = 0;
    int n_fail  = 0;

    matrix_job_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .jobValid(jobValid), .jobReady(jobReady),
        .jobMatrixAddr(jobMatrixAddr), .jobDataInAddr(jobDataInAddr),
        .jobDataOutAddr(jobDataOutAddr), .jobCount(jobCount), .flush(flush),
        .procStart(procStart), .procMatrixAddr(procMatrixAddr),
        .procDataInAddr(procDataInAddr), .procDataOutAddr(procDataOutAddr),
        .procWorkItemCount(procWorkItemCount), .procDone(procDone), .busy(busy),
        .queueLevel(queueLevel), .jobsCompleted(jobsCompleted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] m, input logic [31:0] i, input logic [31:0] o,
                         input logic [13:0] c);
        jobValid       = 1'b1;
        jobMatrixAddr  = m;
        jobDataInAddr  = i;
        jobDataOutAddr = o;
        jobCount       = c;
    endtask

    task automatic push_job(input logic [31:0] m, input logic [13:0] c);
        offer(m, m + 32'h1000, m + 32'h2000, c);
        step();
        jobValid = 1'b0;
    endtask

    task automatic done_pulse();
        procDone = 1'b1;
        step();
        procDone = 1'b0;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_ready", 32'(jobReady), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(procStart), 0);
        chk("rst_level", 32'(queueLevel), 0);
        chk("rst_done_cnt", 32'(jobsCompleted), 0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(jobReady), 1);

        // single job: accepted at E, popped at E+1, start pulse for one cycle
        offer(32'h1000, 32'h2000, 32'h3000, 14'd100);
        step();
        jobValid = 1'b0;
        chk("single_level", 32'(queueLevel), 1);
        chk("single_nostart", 32'(procStart), 0);
        step();
        chk("single_start", 32'(procStart), 1);
        chk("single_busy", 32'(busy), 1);
        chk("single_m", procMatrixAddr, 32'h1000);
        chk("single_i", procDataInAddr, 32'h2000);
        chk("single_o", procDataOutAddr, 32'h3000);
        chk("single_cnt", 32'(procWorkItemCount), 100);
        step();
        chk("single_start_off", 32'(procStart), 0);
        chk("single_run_busy", 32'(busy), 1);
        step();
        done_pulse();
        chk("single_idle", 32'(busy), 0);
        chk("single_done", 32'(jobsCompleted), 1);

        // spurious done in IDLE
        done_pulse();
        chk("spurious_done", 32'(jobsCompleted), 1);

        // fill: job 0 runs, jobs 1..4 fill the queue
        push_job(32'h4000, 14'd1);
        step(); step();
        for (int k = 1; k <= DEPTH; k++) push_job(32'h4000 + 32'(k), 14'(k + 1));
        chk("fill_level", 32'(queueLevel), DEPTH);
        chk("fill_ready", 32'(jobReady), 0);
        done_pulse();
        // full queue: offer during the popping cycle must still be refused
        offer(32'h9999, 32'h9999, 32'h9999, 14'd9);
        chk("full_pop_ready", 32'(jobReady), 0);
        step();
        jobValid = 1'b0;
        chk("full_pop_level", 32'(queueLevel), DEPTH - 1);
        chk("full_ready_back", 32'(jobReady), 1);
        chk("order_1_m", procMatrixAddr, 32'h4001);
        chk("order_1_start", 32'(procStart), 1);
        step();
        for (int k = 2; k <= DEPTH; k++) begin
            done_pulse();
            step();
            chk($sformatf("order_%0d_m", k), procMatrixAddr, 32'h4000 + 32'(k));
            chk($sformatf("order_%0d_cnt", k), 32'(procWorkItemCount), k + 1);
            step();
        end
        done_pulse();
        chk("fill_done", 32'(jobsCompleted), 1 + DEPTH + 1);
        chk("fill_empty", 32'(queueLevel), 0);

        // zero-count job retires without a start pulse; next job launches right after
        push_job(32'h5000, 14'd0);
        offer(32'h5100, 32'h6100, 32'h7100, 14'd5);
        step();
        jobValid = 1'b0;
        chk("zero_retired", 32'(jobsCompleted), 7);
        chk("zero_nostart", 32'(procStart), 0);
        chk("zero_nobusy", 32'(busy), 0);
        chk("zero_level", 32'(queueLevel), 1);
        step();
        chk("zero_next_start", 32'(procStart), 1);
        chk("zero_next_cnt", 32'(procWorkItemCount), 5);
        chk("zero_next_m", procMatrixAddr, 32'h5100);
        step();
        done_pulse();
        chk("zero_done", 32'(jobsCompleted), 8);

        // flush with a job running and three queued
        push_job(32'h7000, 14'd3);
        step(); step();
        for (int k = 0; k < 3; k++) push_job(32'h7100 + 32'(k), 14'd2);
        chk("flush_pre_level", 32'(queueLevel), 3);
        offer(32'h7777, 32'h7777, 32'h7777, 14'd4);
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(jobReady), 0);
        step();
        flush = 1'b0;
        jobValid = 1'b0;
        chk("flush_level", 32'(queueLevel), 0);
        chk("flush_run_busy", 32'(busy), 1);
        chk("flush_run_m", procMatrixAddr, 32'h7000);
        done_pulse();
        chk("flush_done", 32'(jobsCompleted), 9);
        step(); step();
        chk("flush_stay_idle", 32'(busy), 0);
        chk("flush_no_more", 32'(jobsCompleted), 9);

        // reset in the middle of RUN
        push_job(32'h8000, 14'd7);
        step(); step();
        chk("rst_run_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_start", 32'(procStart), 0);
        chk("midrst_m", procMatrixAddr, 0);
        chk("midrst_cnt", 32'(procWorkItemCount), 0);
        chk("midrst_done_cnt", 32'(jobsCompleted), 0);
        chk("midrst_ready", 32'(jobReady), 0);
        chk("midrst_level", 32'(queueLevel), 0);
        step();
        rst = 1'b0;
        done_pulse();
        chk("post_rst_done", 32'(jobsCompleted), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // counter wrap: 65535 zero-count jobs, then one more
        offer(32'h0, 32'h0, 32'h0, 14'd0);
        repeat (65535) step();
        jobValid = 1'b0;
        step();
        chk("wrap_ffff", 32'(jobsCompleted), 32'hFFFF);
        chk("wrap_level", 32'(queueLevel), 0);
        push_job(32'h0, 14'd0);
        step();
        chk("wrap_zero", 32'(jobsCompleted), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_job_scheduler.md
MATRIX_JOB_SCHEDULER -- requirements
Module: matrix_job_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the address width.
REQ-002 SHALL have parameter DEPTH, default 4, the job queue entries; the value SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port jobValid  input  1  host offers a job descriptor.
REQ-006 SHALL have port jobReady  output  1  scheduler accepts the descriptor; a transfer occurs when jobValid and jobReady are both high at a clock edge.
REQ-007 SHALL have ports jobMatrixAddr, jobDataInAddr, jobDataOutAddr  input  WIDTH each  job descriptor addresses.
REQ-008 SHALL have port jobCount  input  14  work-item count of the job.
REQ-009 SHALL have port flush  input  1  discards all queued jobs that have not started.
REQ-010 SHALL have port procStart  output  1  one-cycle start pulse to the matrix processor.
REQ-011 SHALL have ports procMatrixAddr, procDataInAddr, procDataOutAddr  output  WIDTH each  registered job addresses to the processor.
REQ-012 SHALL have port procWorkItemCount  output  14  registered work-item count.
REQ-013 SHALL have port procDone  input  1  single-cycle pulse from the processor marking job completion.
REQ-014 SHALL have port busy  output  1  high while a job is launching or running.
REQ-015 SHALL have port queueLevel  output  $clog2(DEPTH)+1  number of queued jobs.
REQ-016 SHALL have port jobsCompleted  output  16  count of retired jobs; it wraps from 0xFFFF to 0.

Function
REQ-017 SHALL store descriptors in a FIFO of DEPTH entries; jobReady = !full && !flush, with no combinational path from jobValid.
REQ-018 SHALL implement FSM states IDLE, LAUNCH, and RUN.
REQ-019 IDLE with a non-empty queue and jobCount of the head != 0 SHALL, at the edge, pop the head, load all proc* address/count registers, and go to LAUNCH.
REQ-020 IDLE with a head jobCount == 0 SHALL pop the head, increment jobsCompleted, stay in IDLE, and never assert procStart for that job.
REQ-021 LAUNCH SHALL assert procStart for exactly one cycle, then go to RUN.
REQ-022 RUN SHALL hold the proc* registers stable and go to IDLE on procDone, incrementing jobsCompleted at that edge.
REQ-023 procDone in IDLE or LAUNCH SHALL be ignored.
REQ-024 busy SHALL be high in LAUNCH and RUN and low in IDLE.
REQ-025 Latency: a job accepted at edge E into an empty queue with the FSM in IDLE SHALL be popped at edge E+1, with procStart high in the cycle between E+1 and E+2.
REQ-026 Back-to-back jobs: after procDone returns the FSM to IDLE, the next queued job SHALL be popped at the following edge; there is a minimum of one IDLE cycle between jobs.
REQ-027 A simultaneous push and pop SHALL keep queueLevel unchanged and preserve FIFO order.
REQ-028 When full, a push SHALL be refused (jobReady low), including in a cycle where a pop frees an entry; jobReady rises in the next cycle.
REQ-029 flush SHALL empty the queue at the edge, reject any push in that cycle, and pre-empt an IDLE pop in that cycle; a job in LAUNCH or RUN is unaffected.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; queueLevel SHALL range 0..DEPTH.

Reset
REQ-031 rst high SHALL immediately force state IDLE, an empty queue, procStart 0, busy 0, all proc* outputs 0, jobsCompleted 0, queueLevel 0, and jobReady 0 while rst is high.
REQ-032 rst asserted mid-RUN SHALL abandon the job; a later procDone SHALL be ignored and not counted.

Verification
REQ-033 Single job: push {M=0x1000, I=0x2000, O=0x3000, count=100} at edge E -> procStart high only in cycle E+1..E+2, proc* outputs equal the descriptor, busy high; procDone -> busy low, jobsCompleted=1.
REQ-034 Fill: push DEPTH+1 jobs while the first runs -> the 1st job launches, DEPTH jobs queue, queueLevel=DEPTH, jobReady low; procDone pulses -> jobs launch in push order and jobsCompleted=DEPTH+1.
REQ-035 Zero count: queue jobs count=0, then count=5 -> first retired without procStart (jobsCompleted=1), second launched next edge.
REQ-036 Flush: three jobs queued, one running; assert flush with jobValid -> queueLevel=0, push rejected, the running job completes normally, jobsCompleted +1 only.
REQ-037 Spurious/reset: procDone in IDLE -> no count change; rst pulse during RUN -> all outputs 0 at once, and a following procDone is not counted.
REQ-038 Wrap: preload 0xFFFF completions via 65535 zero-count jobs, then one more job -> jobsCompleted=0.
